cur_block_pingpong_buf: RTL and testbench
=========================================

Name: cur_block_pingpong_buf

Overview:
Parametrised current-block buffer for the motion-estimation datapath. It packs a narrow pixel input stream into a full BLK_W x BLK_H current block for the SAD/PE array. Two register banks run ping-pong: the next block loads while the active block is being searched. The block provides a valid/ready input handshake, full-block and per-row read ports, and a synchronous flush.

Parameters:
PIX_W, 8, bits per pixel
BLK_W, 8, block width in pixels
BLK_H, 8, block height in pixels
IN_PIX, 4, pixels per input word; BLK_W*BLK_H must be divisible by IN_PIX
Derived: WORDS = BLK_W*BLK_H/IN_PIX (16 at defaults); BLK_BITS = BLK_W*BLK_H*PIX_W (512); RS_W = max(1, clog2(BLK_H))

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high; clock clk
flush  in  1  synchronous clear of fill and active state
in_data  in  IN_PIX*PIX_W  input pixel word; pixel k is in bits [k*PIX_W +: PIX_W]
in_valid  in  1  in_data valid
in_ready  out  1  fill bank can accept a word
next_block  in  1  consumer has finished the active block (one-cycle pulse)
blk_out  out  BLK_BITS  active block; pixel p is in bits [p*PIX_W +: PIX_W], raster order
blk_valid  out  1  blk_out holds a complete block
blk_start  out  1  one-cycle pulse on the cycle a new block first becomes valid
row_sel  in  RS_W  row index for row_out
row_out  out  BLK_W*PIX_W  combinational: row row_sel of the active bank

Behaviour:
- State: bank[0..1], wr_sel (fill bank index), act_sel = ~wr_sel, wr_ptr (0..WORDS-1), fill_full, blk_valid.
- Reset (async): both banks = 0, wr_sel = 0, wr_ptr = 0, fill_full = 0, blk_valid = 0, blk_start = 0. After reset in_ready = 1, blk_out = 0, row_out = 0.
- in_ready = ~fill_full.
- Accept occurs when in_valid && in_ready. Pixel k of the accepted word is written to linear index wr_ptr*IN_PIX + k of bank[wr_sel]. wr_ptr then increments.
- When the accepted word has wr_ptr == WORDS-1: wr_ptr wraps to 0 and fill_full = 1 from the next cycle, so in_ready drops after exactly WORDS accepts.
- Swap condition is evaluated on the registered fill_full: fill_full && (~blk_valid || next_block). On swap:
  - wr_sel toggles.
  - fill_full = 0, so in_ready = 1 next cycle.
  - blk_valid = 1 and blk_start = 1 for one cycle.
- Release: next_block && blk_valid && ~fill_full sets blk_valid = 0 next cycle. The bank is not modified.
- next_block while blk_valid = 0 is ignored.
- Latency: last word accepted at edge N gives fill_full high after N. If the active bank is empty, the swap happens at edge N+1, so blk_valid and blk_start are high after N+1.
- next_block on the same edge as the last-word accept: the release applies first. The block then auto-promotes one cycle later (blk_valid low for exactly 1 cycle).
- Fill restarts immediately after a swap. Up to WORDS words can be accepted while the active bank is held; they are never dropped or overwritten.
- blk_out and row_out always reflect bank[act_sel]. When blk_valid = 0 the content is stale and must not be consumed.
- row_out = blk_out[row_sel*BLK_W*PIX_W +: BLK_W*PIX_W]. A row_sel >= BLK_H returns 0.
- flush has priority over accept, swap and release:
  - Clears wr_ptr, fill_full, blk_valid and blk_start next cycle.
  - Bank data and wr_sel are untouched.
  - An in_valid presented in the flush cycle is not accepted (in_ready still reads 1 but the write is suppressed).
- rst mid-fill aborts the partial block. The next fill starts at word 0 of bank 0.

Test Plan:
1. Reset, then 16 consecutive words of bytes 0x00..0x3F (byte 0 in LSB) with in_valid held high -> in_ready high for 16 accepts then low for 1 cycle. blk_valid and a single blk_start arrive one cycle after the last accept. blk_out[7:0] = 0x00, blk_out[511:504] = 0x3F, in_ready high again.
2. Feed a second block 0x40..0x7F with no next_block -> 16 accepts then in_ready = 0; blk_out still shows 0x00..0x3F. Pulse next_block -> next cycle blk_out[7:0] = 0x40, blk_start = 1, in_ready = 1.
3. in_valid asserted every other cycle with random stalls -> wr_ptr advances only on handshake; final blk_out is identical to scenario 1.
4. After 8 of 16 words, pulse next_block -> blk_valid = 0 next cycle. Feed the remaining 8 words -> auto-promote: blk_valid = 1 one cycle after the last accept.
5. Block 0x00..0x3F valid, row_sel = 3 -> row_out = bytes 0x18..0x1F. row_sel = 7 -> 0x38..0x3F.
6. Assert rst after 5 accepted words -> all outputs at reset values immediately. Reload 16 words -> correct block with pixel 0 from the first post-reset word. Repeat with flush instead -> same outcome, and blk_valid clears next cycle.

Source files
------------

// File: rtl/cur_block_pingpong_buf.sv
// cur_block_pingpong_buf: packs an input pixel stream into full blocks across two ping-pong banks.
module cur_block_pingpong_buf #(
    parameter int PIX_W  = 8,
    parameter int BLK_W  = 8,
    parameter int BLK_H  = 8,
    parameter int IN_PIX = 4,
    localparam int WORDS    = BLK_W * BLK_H / IN_PIX,
    localparam int BLK_BITS = BLK_W * BLK_H * PIX_W,
    localparam int RS_W     = (BLK_H > 1) ? $clog2(BLK_H) : 1,
    localparam int WORD_W   = IN_PIX * PIX_W,
    localparam int ROW_W    = BLK_W * PIX_W,
    localparam int PTR_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                next_block,
    output logic [BLK_BITS-1:0] blk_out,
    output logic                blk_valid,
    output logic                blk_start,
    input  logic [RS_W-1:0]     row_sel,
    output logic [ROW_W-1:0]    row_out
);
    logic [BLK_BITS-1:0] bank_q [2];
    logic [BLK_BITS-1:0] bank_d [2];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic wr_sel_q, wr_sel_d;
    logic fill_full_q, fill_full_d;
    logic blk_valid_q, blk_valid_d;
    logic blk_start_q, blk_start_d;
    logic accept, last, swap, rel;
    always_comb begin
        accept = in_valid && !fill_full_q && !flush;
        last = accept && (wr_ptr_q == PTR_W'(WORDS - 1));
        swap = fill_full_q && (!blk_valid_q || next_block);
        rel = next_block && blk_valid_q && !fill_full_q;
        bank_d = bank_q;
        for (int w = 0; w < WORDS; w++)
            if (accept && wr_ptr_q == PTR_W'(w)) bank_d[wr_sel_q][w*WORD_W +: WORD_W] = in_data;
        wr_ptr_d = (flush || last) ? '0 : accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_full_d = !flush && (last || (fill_full_q && !swap));
        blk_valid_d = !flush && (swap || (blk_valid_q && !rel));
        blk_start_d = !flush && swap;
        wr_sel_d = wr_sel_q ^ (swap && !flush);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            wr_ptr_q <= '0;
            wr_sel_q <= 1'b0;
            fill_full_q <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_start_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            wr_ptr_q <= wr_ptr_d;
            wr_sel_q <= wr_sel_d;
            fill_full_q <= fill_full_d;
            blk_valid_q <= blk_valid_d;
            blk_start_q <= blk_start_d;
        end
    end
    assign in_ready = !fill_full_q;
    assign blk_out = bank_q[~wr_sel_q];
    assign blk_valid = blk_valid_q;
    assign blk_start = blk_start_q;
    // out-of-range row_sel matches no row and yields zero
    always_comb begin
        row_out = '0;
        for (int r = 0; r < BLK_H; r++)
            if (row_sel == RS_W'(r)) row_out = blk_out[r*ROW_W +: ROW_W];
    end
endmodule

// File: tb/tb_cur_block_pingpong_buf.sv
// tb_cur_block_pingpong_buf: table vectors, directed corner sequences and random traffic against a block-level model.
module tb_cur_block_pingpong_buf;
    localparam int WORDS = 16, BLK_BITS = 512, WW = 32, RW = 64, RS_W = 3;
    logic clk = 0, rst = 0, flush = 0, in_valid = 0, next_block = 0;
    logic [WW-1:0] in_data = '0;
    logic [RS_W-1:0] row_sel = '0;
    logic in_ready, blk_valid, blk_start;
    logic [BLK_BITS-1:0] blk_out;
    logic [RW-1:0] row_out;
    int checks = 0, failures = 0;
    int m_cnt;
    logic m_valid, m_start;
    logic [BLK_BITS-1:0] m_fill, m_act;

    cur_block_pingpong_buf dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .next_block(next_block), .blk_out(blk_out), .blk_valid(blk_valid),
        .blk_start(blk_start), .row_sel(row_sel), .row_out(row_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic f, v, nb;
        logic ready, bv, bs;
        logic [7:0] b0, top;
    } vec_t;
    vec_t tbl [36];

    task automatic chk(string name, logic [BLK_BITS-1:0] act, logic [BLK_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] wordof(int base);
        logic [WW-1:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(base + k);
        return d;
    endfunction

    function automatic logic [BLK_BITS-1:0] ramp(int base);
        logic [BLK_BITS-1:0] r;
        for (int p = 0; p < 64; p++) r[p*8 +: 8] = 8'(base + p);
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_valid = 0; m_start = 0; m_fill = '0; m_act = '0;
    endtask

    task automatic model_step();
        logic full;
        full = (m_cnt == WORDS);
        if (flush) begin
            m_cnt = 0; m_valid = 0; m_start = 0;
        end else if (full && (!m_valid || next_block)) begin
            m_act = m_fill; m_valid = 1; m_start = 1; m_cnt = 0;
        end else begin
            m_start = 0;
            if (next_block && m_valid) m_valid = 0;
            if (in_valid && !full) begin
                m_fill[m_cnt*WW +: WW] = in_data;
                m_cnt++;
            end
        end
    endtask

    task automatic check_model();
        int idx;
        idx = row_sel;
        chk("m_in_ready", in_ready, m_cnt != WORDS);
        chk("m_blk_valid", blk_valid, m_valid);
        chk("m_blk_start", blk_start, m_start);
        chk("m_blk_out", blk_out, m_act);
        chk("m_row_out", row_out, m_act[idx*RW +: RW]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic step(logic f, logic v, logic [WW-1:0] d, logic nb);
        flush = f; in_valid = v; in_data = d; next_block = nb;
        tick();
    endtask

    task automatic feed(int base, int n);
        for (int j = 0; j < n; j++) step(0, 1, wordof(base + 4*j), 0);
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; in_valid = 0; next_block = 0;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int wi, w, cyc;
        logic prev_ready, acc;
        logic [RW-1:0] er;
        for (int i = 0; i < 36; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[15].ready = 0;
        for (int i = 16; i < 36; i++) begin tbl[i].bv = 1; tbl[i].top = 8'h3F; end
        tbl[16].bs = 1;
        tbl[32].ready = 0;
        tbl[33].v = 0; tbl[33].ready = 0;
        tbl[34].v = 0; tbl[34].nb = 1; tbl[34].bs = 1; tbl[34].b0 = 8'h40; tbl[34].top = 8'h7F;
        tbl[35].v = 0; tbl[35].b0 = 8'h40; tbl[35].top = 8'h7F;

        do_reset();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_blk_out", blk_out, '0);
        wi = 0; prev_ready = 1;
        for (int i = 0; i < 36; i++) begin
            step(tbl[i].f, tbl[i].v, wordof(4*wi), tbl[i].nb);
            if (tbl[i].v && prev_ready && !tbl[i].f) wi++;
            prev_ready = tbl[i].ready;
            chk($sformatf("t%0d_ready", i), in_ready, tbl[i].ready);
            chk($sformatf("t%0d_valid", i), blk_valid, tbl[i].bv);
            chk($sformatf("t%0d_start", i), blk_start, tbl[i].bs);
            chk($sformatf("t%0d_b0", i), blk_out[7:0], tbl[i].b0);
            chk($sformatf("t%0d_top", i), blk_out[511:504], tbl[i].top);
        end

        do_reset();
        w = 0; cyc = 0;
        while (w < WORDS && cyc < 400) begin
            acc = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
            step(0, acc, wordof(4*w), 0);
            if (acc) w++;
            cyc++;
        end
        chk("stall_words", 32'(w), 32'(WORDS));
        in_valid = 0;
        cyc = 0;
        while (!blk_valid && cyc < 5) begin tick(); cyc++; end
        chk("stall_valid", blk_valid, 1'b1);
        chk("stall_block", blk_out, ramp(0));

        row_sel = 3; #1;
        for (int k = 0; k < 8; k++) er[k*8 +: 8] = 8'(8'h18 + k);
        chk("row3", row_out, er);
        row_sel = 7; #1;
        for (int k = 0; k < 8; k++) er[k*8 +: 8] = 8'(8'h38 + k);
        chk("row7", row_out, er);
        row_sel = 0;

        feed(8'h80, 8);
        step(0, 0, '0, 1);
        chk("rel_valid", blk_valid, 1'b0);
        chk("rel_ready", in_ready, 1'b1);
        feed(8'h80 + 32, 8);
        chk("auto_pre_valid", blk_valid, 1'b0);
        chk("auto_pre_ready", in_ready, 1'b0);
        step(0, 0, '0, 0);
        chk("auto_valid", blk_valid, 1'b1);
        chk("auto_start", blk_start, 1'b1);
        chk("auto_block", blk_out, ramp(8'h80));

        feed(8'hC0, 15);
        step(0, 1, wordof(8'hC0 + 60), 1);
        chk("same_edge_valid", blk_valid, 1'b0);
        step(0, 0, '0, 0);
        chk("same_edge_promote", blk_valid, 1'b1);
        chk("same_edge_start", blk_start, 1'b1);
        chk("same_edge_block", blk_out, ramp(8'hC0));

        feed(8'h10, 5);
        @(negedge clk);
        rst = 1; #1;
        model_reset();
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_valid", blk_valid, 1'b0);
        chk("arst_start", blk_start, 1'b0);
        chk("arst_blk", blk_out, '0);
        chk("arst_row", row_out, '0);
        in_valid = 0; next_block = 0;
        @(posedge clk);
        #1 rst = 0;
        feed(8'h20, 16);
        step(0, 0, '0, 0);
        chk("rst_reload_valid", blk_valid, 1'b1);
        chk("rst_reload_block", blk_out, ramp(8'h20));

        feed(8'h50, 5);
        flush = 1; in_valid = 1; in_data = 32'hEEEE_EEEE; #1;
        chk("flush_ready_pre", in_ready, 1'b1);
        tick();
        chk("flush_valid", blk_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        feed(8'h60, 16);
        step(0, 0, '0, 0);
        chk("flush_reload_valid", blk_valid, 1'b1);
        chk("flush_reload_block", blk_out, ramp(8'h60));

        for (int i = 0; i < 1500; i++) begin
            row_sel = RS_W'($urandom);
            step($urandom_range(0, 49) == 0, 1'($urandom), $urandom, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
